// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute/memory-bus/writeback signal bundle for mem_stage
// Optional: MEM_MISALIGN_TRAP_EN adds the misalign_fault signal.
interface mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [4:0]  in_rd;
  logic [63:0] in_result;

  logic        mem_req_valid;
  logic        mem_req_we;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  // slave: the memory stage's own view of the bundle
  modport slave (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd, in_result,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output wb_en, wb_rd, wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    , output misalign_fault
`endif
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd, in_result,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  wb_en, wb_rd, wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    , input misalign_fault
`endif
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - single-outstanding load/store/passthrough memory stage
// Optional: MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of issuing them.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB
`ifdef MEM_MISALIGN_TRAP_EN
    , S_FAULT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] data_q, data_d;

  logic [2:0]  off;
  logic [5:0]  shamt;
  logic [63:0] field;
  logic [63:0] load_val;
  logic [7:0]  size_mask;
  logic [7:0]  strb;

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] o);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return o[0];
      2'b10:   return |o[1:0];
      default: return |o;
    endcase
  endfunction
`endif

  // Lanes pushed past byte 7 fall off the end; crossing accesses are never split.
  always_comb begin
    off   = addr_q[2:0];
    shamt = {off, 3'b000};
    field = bus.mem_resp_data >> shamt;
    case (funct3_q)
      3'b000:  load_val = {{56{field[7]}},  field[7:0]};
      3'b001:  load_val = {{48{field[15]}}, field[15:0]};
      3'b010:  load_val = {{32{field[31]}}, field[31:0]};
      3'b100:  load_val = {56'd0, field[7:0]};
      3'b101:  load_val = {48'd0, field[15:0]};
      3'b110:  load_val = {32'd0, field[31:0]};
      default: load_val = field;
    endcase
    case (funct3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    strb = size_mask << off;
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    data_d     = data_q;

    bus.in_ready      = (state_q == S_IDLE);
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = {addr_q[63:3], 3'b000};
    bus.mem_req_wdata = wdata_q << shamt;
    bus.mem_req_wstrb = 8'h00;
    bus.wb_en         = 1'b0;
    bus.wb_rd         = rd_q;
    bus.wb_data       = data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    bus.misalign_fault = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          is_store_d = bus.in_is_store;
          funct3_d   = bus.in_funct3;
          addr_d     = bus.in_addr;
          wdata_d    = bus.in_wdata;
          rd_d       = bus.in_rd;
          data_d     = bus.in_result;
          if (bus.in_is_store || bus.in_is_load) begin
            state_d = S_REQ;
`ifdef MEM_MISALIGN_TRAP_EN
            if (misaligned(bus.in_funct3, bus.in_addr[2:0]))
              state_d = S_FAULT;
`endif
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = is_store_q;
        bus.mem_req_wstrb = is_store_q ? strb : 8'h00;
        if (bus.mem_req_ready)
          state_d = is_store_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          data_d  = load_val;
          state_d = S_WB;
        end
      end
      S_WB: begin
        bus.wb_en = (rd_q != 5'd0);
        state_d   = S_IDLE;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      S_FAULT: begin
        bus.misalign_fault = 1'b1;
        state_d            = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      rd_q       <= 5'd0;
      data_q     <= 64'd0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - vector table, corner sequences and random ops for mem_stage
// Optional: MEM_MISALIGN_TRAP_EN selects the trapping expectations.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus();
  mem_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int wb_seen  = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] result;
    logic [63:0] resp;
    logic [4:0]  rd;
    int          rdly;
    int          pdly;
    logic        exp_wb;
    logic [63:0] exp_data;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    wb_seen += int'(bus.wb_en);
  endtask

  // Reference model: byte-by-byte view of the access
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    int n = 1 << f3[1:0];
    int o = int'(a[2:0]);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++)
      if (o + i < 8) v[8*i +: 8] = d[8*(o+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [2:0] f3, input logic [63:0] a);
    int n = 1 << f3[1:0];
    int o = int'(a[2:0]);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < n; i++)
      if (o + i < 8) s[o+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    int n = 1 << f3[1:0];
    int o = int'(a[2:0]);
    logic [63:0] w = 64'd0;
    for (int i = 0; i < n; i++)
      if (o + i < 8) w[8*(o+i) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m = 64'd0;
    for (int i = 0; i < 8; i++)
      if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic ref_mis(input logic [2:0] f3, input logic [63:0] a);
    int n = 1 << f3[1:0];
    return (int'(a[2:0]) % n) != 0;
  endfunction

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] result, input logic [63:0] resp,
                              input logic [4:0] rd, input int rdly, input int pdly,
                              input logic ewb, input logic [63:0] edata, input logic [63:0] eaddr,
                              input logic [7:0] estrb, input logic [63:0] ewdata);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.result = result; v.resp = resp; v.rd = rd; v.rdly = rdly; v.pdly = pdly;
    v.exp_wb = ewb; v.exp_data = edata; v.exp_addr = eaddr;
    v.exp_strb = estrb; v.exp_wdata = ewdata;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_is_load = 1'b0; bus.in_is_store = 1'b0;
    bus.in_funct3 = 3'd0; bus.in_addr = 64'd0; bus.in_wdata = 64'd0;
    bus.in_rd = 5'd0; bus.in_result = 64'd0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 64'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("rst.in_ready", bus.in_ready, 1);
    chk("rst.req_valid", bus.mem_req_valid, 0);
    chk("rst.req_we", bus.mem_req_we, 0);
    chk("rst.wstrb", bus.mem_req_wstrb, 0);
    chk("rst.wb_en", bus.wb_en, 0);
    chk("rst.wb_rd", bus.wb_rd, 0);
    chk("rst.wb_data", bus.wb_data, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst.fault", bus.misalign_fault, 0);
`endif
    reset = 1'b0;
  endtask

  task automatic xact(input vec_t v, input string nm);
    logic is_mem;
    logic [63:0] m;
    is_mem  = v.ld || v.st;
    m       = lane_mask(v.exp_strb);
    wb_seen = 0;
    chk({nm, ".in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_is_load = v.ld; bus.in_is_store = v.st;
    bus.in_funct3 = v.f3; bus.in_addr = v.addr; bus.in_wdata = v.wdata;
    bus.in_rd = v.rd; bus.in_result = v.result;
    tick();
    bus.in_valid = 1'b0;
    bus.in_addr = {$urandom, $urandom}; bus.in_wdata = {$urandom, $urandom};
    bus.in_result = {$urandom, $urandom}; bus.in_rd = 5'($urandom);
`ifdef MEM_MISALIGN_TRAP_EN
    if (is_mem && ref_mis(v.f3, v.addr)) begin
      chk({nm, ".fault"}, bus.misalign_fault, 1);
      chk({nm, ".fault_noreq"}, bus.mem_req_valid, 0);
      tick();
      chk({nm, ".fault_pulse"}, bus.misalign_fault, 0);
      chk({nm, ".fault_noreq2"}, bus.mem_req_valid, 0);
      chk({nm, ".fault_ready"}, bus.in_ready, 1);
      chk({nm, ".fault_nowb"}, wb_seen, 0);
      return;
    end
`endif
    if (!is_mem) begin
      chk({nm, ".wb_en"}, bus.wb_en, v.exp_wb);
      if (v.exp_wb) begin
        chk({nm, ".wb_rd"}, bus.wb_rd, v.rd);
        chk({nm, ".wb_data"}, bus.wb_data, v.exp_data);
      end
      tick();
      chk({nm, ".wb_drop"}, bus.wb_en, 0);
      chk({nm, ".ready_back"}, bus.in_ready, 1);
    end else begin
      for (int c = 0; c <= v.rdly; c++) begin
        chk({nm, ".req_valid"}, bus.mem_req_valid, 1);
        chk({nm, ".req_we"}, bus.mem_req_we, v.st);
        chk({nm, ".req_addr"}, bus.mem_req_addr, v.exp_addr);
        if (v.st) begin
          chk({nm, ".wstrb"}, bus.mem_req_wstrb, v.exp_strb);
          chk({nm, ".wdata"}, bus.mem_req_wdata & m, v.exp_wdata & m);
        end
        if (c == 0) begin
          chk({nm, ".busy"}, bus.in_ready, 0);
          // stray op while busy must be ignored
          bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_is_store = 1'b0;
          bus.in_rd = 5'd7;
        end
        if (c == v.rdly) bus.mem_req_ready = 1'b1;
        tick();
      end
      bus.mem_req_ready = 1'b0;
      bus.in_valid = 1'b0;
      chk({nm, ".req_drop"}, bus.mem_req_valid, 0);
      if (v.st) begin
        chk({nm, ".st_ready"}, bus.in_ready, 1);
      end else begin
        for (int c = 0; c < v.pdly; c++) tick();
        chk({nm, ".wait_busy"}, bus.in_ready, 0);
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = v.resp;
        tick();
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = {$urandom, $urandom};
        chk({nm, ".wb_en"}, bus.wb_en, v.exp_wb);
        if (v.exp_wb) begin
          chk({nm, ".wb_rd"}, bus.wb_rd, v.rd);
          chk({nm, ".wb_data"}, bus.wb_data, v.exp_data);
        end
        tick();
        chk({nm, ".wb_drop"}, bus.wb_en, 0);
        chk({nm, ".ready_back"}, bus.in_ready, 1);
      end
    end
    chk({nm, ".wb_count"}, wb_seen, v.exp_wb ? 1 : 0);
  endtask

  vec_t tbl[16];
  vec_t rv;
  logic [1:0] kind;

  initial begin
    idle_inputs();
    reset = 1'b1;
    do_reset();

    tbl[0]  = mk(0, 0, 3'b000, 64'h0,    64'h0, 64'h1234, 64'h0, 5'd5, 0, 0, 1, 64'h1234, 64'h0, 8'h00, 64'h0);
    tbl[1]  = mk(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 5'd4, 1, 2, 1, 64'hFFFF_FFFF_FFFF_FF80, 64'h1000, 8'h00, 64'h0);
    tbl[2]  = mk(1, 0, 3'b100, 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 5'd6, 0, 0, 1, 64'h80, 64'h1000, 8'h00, 64'h0);
    tbl[3]  = mk(0, 1, 3'b001, 64'h2006, 64'hBEEF, 64'h0, 64'h0, 5'd1, 3, 0, 0, 64'h0, 64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000);
    tbl[4]  = mk(1, 0, 3'b010, 64'h10,   64'h0, 64'h0, 64'hFFFF_FFFF_7FFF_FFFF, 5'd0, 0, 1, 0, 64'h0, 64'h10, 8'h00, 64'h0);
    tbl[5]  = mk(1, 0, 3'b010, 64'h10,   64'h0, 64'h0, 64'hFFFF_FFFF_7FFF_FFFF, 5'd3, 0, 1, 1, 64'h7FFF_FFFF, 64'h10, 8'h00, 64'h0);
    tbl[6]  = mk(1, 0, 3'b011, 64'h18,   64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd31, 1, 0, 1, 64'h0123_4567_89AB_CDEF, 64'h18, 8'h00, 64'h0);
    tbl[7]  = mk(1, 0, 3'b001, 64'h6,    64'h0, 64'h0, 64'hABCD_0000_0000_0000, 5'd8, 0, 0, 1, 64'hFFFF_FFFF_FFFF_ABCD, 64'h0, 8'h00, 64'h0);
    tbl[8]  = mk(1, 0, 3'b101, 64'h6,    64'h0, 64'h0, 64'hABCD_0000_0000_0000, 5'd9, 0, 0, 1, 64'hABCD, 64'h0, 8'h00, 64'h0);
    tbl[9]  = mk(0, 1, 3'b010, 64'h104,  64'hDEAD_BEEF_1122_3344, 64'h0, 64'h0, 5'd2, 0, 0, 0, 64'h0, 64'h100, 8'hF0, 64'h1122_3344_0000_0000);
    tbl[10] = mk(0, 1, 3'b111, 64'h200,  64'hCAFE_F00D_1234_5678, 64'h0, 64'h0, 5'd2, 2, 0, 0, 64'h0, 64'h200, 8'hFF, 64'hCAFE_F00D_1234_5678);
    tbl[11] = mk(1, 0, 3'b110, 64'h5,    64'h0, 64'h0, 64'h8877_6655_4433_2211, 5'd12, 0, 0, 1, 64'h88_7766, 64'h0, 8'h00, 64'h0);
    tbl[12] = mk(0, 1, 3'b010, 64'h6,    64'h1122_3344, 64'h0, 64'h0, 5'd1, 1, 0, 0, 64'h0, 64'h0, 8'hC0, 64'h3344_0000_0000_0000);
    tbl[13] = mk(0, 0, 3'b000, 64'h0,    64'h0, 64'hFFFF, 64'h0, 5'd0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 64'h0);
    tbl[14] = mk(0, 1, 3'b000, 64'h7,    64'hAB, 64'h0, 64'h0, 5'd1, 0, 0, 0, 64'h0, 64'h0, 8'h80, 64'hAB00_0000_0000_0000);
    tbl[15] = mk(1, 0, 3'b010, 64'h4,    64'h0, 64'h0, 64'h8000_0001_0000_0000, 5'd2, 0, 3, 1, 64'hFFFF_FFFF_8000_0001, 64'h0, 8'h00, 64'h0);

    for (int i = 0; i < 16; i++) xact(tbl[i], $sformatf("vec%0d", i));

    // response outside WAIT is ignored, next passthrough unaffected
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'hDEAD;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("stray_resp.wb", bus.wb_en, 0);
    chk("stray_resp.ready", bus.in_ready, 1);
    xact(mk(0, 0, 3'b000, 64'h0, 64'h0, 64'h55AA, 64'h0, 5'd10, 0, 0, 1, 64'h55AA, 64'h0, 8'h00, 64'h0), "after_stray");

    // reset while waiting for a load response
    wb_seen = 0;
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_is_store = 1'b0;
    bus.in_funct3 = 3'b010; bus.in_addr = 64'h40; bus.in_rd = 5'd9;
    tick();
    bus.in_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    chk("rst_wait.in_wait", bus.in_ready, 0);
    reset = 1'b1;
    tick();
    chk("rst_wait.ready", bus.in_ready, 1);
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'h1234_5678;
    tick();
    bus.mem_resp_valid = 1'b0;
    tick();
    tick();
    chk("rst_wait.nowb", wb_seen, 0);
    chk("rst_wait.idle", bus.in_ready, 1);

    // reset while a store request is pending
    bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_is_store = 1'b1;
    bus.in_funct3 = 3'b011; bus.in_addr = 64'h80;
    tick();
    bus.in_valid = 1'b0; bus.in_is_store = 1'b0;
    chk("rst_req.req", bus.mem_req_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_req.drop", bus.mem_req_valid, 0);
    chk("rst_req.strb", bus.mem_req_wstrb, 0);
    chk("rst_req.ready", bus.in_ready, 1);

`ifdef MEM_MISALIGN_TRAP_EN
    xact(mk(1, 0, 3'b010, 64'h1002, 64'h0, 64'h0, 64'h0, 5'd3, 0, 0, 0, 64'h0, 64'h1000, 8'h00, 64'h0), "trap_lw");
`endif

    for (int i = 0; i < 150; i++) begin
      kind = 2'($urandom_range(0, 2));
      rv.ld = (kind == 2'd1);
      rv.st = (kind == 2'd2);
      rv.f3 = rv.st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      if (rv.st && ($urandom_range(0, 4) == 0)) rv.f3 = 3'b111;
      rv.addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) rv.addr[2:0] = 3'd0;
      rv.wdata = {$urandom, $urandom};
      rv.result = {$urandom, $urandom};
      rv.resp = {$urandom, $urandom};
      rv.rd = 5'($urandom);
      rv.rdly = $urandom_range(0, 3);
      rv.pdly = $urandom_range(0, 3);
      rv.exp_wb = !rv.st && (rv.rd != 5'd0);
      rv.exp_data = rv.ld ? ref_load(rv.f3, rv.addr, rv.resp) : rv.result;
      rv.exp_addr = {rv.addr[63:3], 3'b000};
      rv.exp_strb = rv.st ? ref_strb(rv.f3, rv.addr) : 8'h00;
      rv.exp_wdata = ref_wdata(rv.f3, rv.addr, rv.wdata);
      xact(rv, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  execute stage presents an operation this cycle.
REQ-004 in_ready  output  1  stage can accept; high only in IDLE.
REQ-005 in_is_load / in_is_store  input  1 each  operation class; both low = ALU passthrough; both high never driven (store wins).
REQ-006 in_funct3  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 011 ld/sd, 100 lbu, 101 lhu, 110 lwu; sb/sh/sw use 000/001/010.
REQ-007 in_addr  input  64  effective byte address from the ALU.
REQ-008 in_wdata  input  64  store data, right-aligned.
REQ-009 in_rd  input  5  destination register.
REQ-010 in_result  input  64  ALU result for passthrough ops.
REQ-011 mem_req_valid, mem_req_we  output  1 each  bus request and write flag.
REQ-012 mem_req_ready  input  1  bus accepts the request this cycle.
REQ-013 mem_req_addr  output  64  in_addr with bits [2:0] cleared.
REQ-014 mem_req_wdata  output  64;  mem_req_wstrb  output  8  lane-shifted store data and byte strobes.
REQ-015 mem_resp_valid  input  1;  mem_resp_data  input  64  load response, one cycle, aligned doubleword.
REQ-016 wb_en  output  1;  wb_rd  output  5;  wb_data  output  64  register-file write port, one-cycle pulse.
REQ-017 misalign_fault  output  1  present only with MEM_MISALIGN_TRAP_EN.

Function
REQ-018 FSM states IDLE, REQ, WAIT, WB; in_valid && in_ready captures all in_* into registers.
REQ-019 IDLE: passthrough capture -> WB; load or store capture -> REQ; no in_valid -> stay.
REQ-020 REQ: mem_req_valid=1, address/we/wdata/wstrb from captured registers, held stable until mem_req_ready.
REQ-021 REQ with mem_req_ready: store -> IDLE (no writeback, no response awaited); load -> WAIT.
REQ-022 WAIT: on mem_resp_valid register extracted data -> WB; otherwise stay, no timeout.
REQ-023 WB: wb_en=1 for exactly one cycle with wb_rd = captured rd, then IDLE; wb_en forced 0 when rd==0.
REQ-024 Latency: passthrough wb_en one cycle after accept; load wb_en one cycle after mem_resp_valid; earliest next accept is the cycle after WB or after store handshake.
REQ-025 Load extraction: byte offset o=addr[2:0]; field = resp_data >> (8*o); lb/lh/lw sign-extend bit 7/15/31; lbu/lhu/lwu zero-extend; ld uses full 64 bits.
REQ-026 Store lanes: wstrb = 0x01/0x03/0x0F/0xFF for b/h/w/d shifted left by o; wdata = in_wdata << (8*o); bits outside strobes don't-care.
REQ-027 Accesses that cross the 8-byte boundary are not split; lanes shifted past bit 63/strobe bit 7 are discarded (baseline behaviour).
REQ-028 mem_resp_valid outside WAIT is ignored; in_valid outside IDLE is ignored (in_ready=0).
REQ-029 Unused in_funct3 value 111 treated as ld/sd.

Reset
REQ-030 Reset forces IDLE; in_ready=1, mem_req_valid=0, mem_req_we=0, mem_req_wstrb=0, wb_en=0, wb_rd=0, wb_data=0, misalign_fault=0.
REQ-031 Reset mid-operation (REQ/WAIT/WB) abandons the operation: no writeback; a response arriving afterwards is ignored per REQ-028.

Configuration
REQ-032 Macro MEM_MISALIGN_TRAP_EN: when defined, an access with addr not aligned to its size (h: o[0], w: o[1:0], d: o[2:0] nonzero) issues no bus request, no writeback, pulses misalign_fault one cycle after accept, returns to IDLE.
REQ-033 Without MEM_MISALIGN_TRAP_EN: misalign_fault port absent, misaligned accesses follow REQ-027.

Verification
REQ-034 Passthrough in_result=0x1234, rd=5 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1234, one cycle only.
REQ-035 lb addr=0x1003, resp_data=0x00000000_80000000 -> wb_data=0xFFFFFFFF_FFFFFF80; lbu same -> 0x80.
REQ-036 sh addr=0x2006, wdata=0xBEEF, mem_req_ready low 3 cycles -> request held stable; mem_req_addr=0x2000, wstrb=0xC0, wdata[63:48]=0xBEEF; no wb_en.
REQ-037 lw rd=0 addr=0x10, resp 0xFFFFFFFF_7FFFFFFF -> wb_en stays 0; same with rd=3 -> wb_data=0x7FFFFFFF.
REQ-038 Reset asserted in WAIT, then mem_resp_valid -> no wb_en, in_ready=1 after reset.
REQ-039 With MEM_MISALIGN_TRAP_EN, lw addr=0x1002 -> misalign_fault one-cycle pulse, mem_req_valid never asserted, no wb_en.
